// File: rtl/sample_clk_sequencer.sv
// Avalon-MM programmable sample-clock generator: free-running or counted-burst square wave plus per-sample strobe.
// Optional level interrupt on burst completion when SAMPLE_CLK_IRQ_EN is defined.
module sample_clk_sequencer #(
    parameter int DIV_W = 16,
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        sample_clk,
    output logic        sample_strobe
`ifdef SAMPLE_CLK_IRQ_EN
    ,
    output logic        irq
`endif
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d, phase_q, phase_d, div_eff;
    logic [CNT_W-1:0]   burst_q, burst_d, count_q, count_d;
    logic               run_q, run_d, cont_q, cont_d, done_q, done_d;
    logic               sclk_q, sclk_d, strobe_q, strobe_d;
    logic               wr_en, busy, phase_last;
    logic               unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign busy         = (state_q != IDLE);
    assign div_eff      = (div_q == '0) ? DIV_W'(1) : div_q;
    assign phase_last   = (phase_q <= DIV_W'(1));
    assign unused_wdata = ^writedata;

    always_comb begin
        // NOTE: every next-state signal gets its hold value first so no path can infer a latch.
        state_d  = state_q;
        phase_d  = phase_q;
        div_d    = div_q;
        burst_d  = burst_q;
        count_d  = count_q;
        run_d    = run_q;
        cont_d   = cont_q;
        done_d   = done_q;
        sclk_d   = sclk_q;
        strobe_d = 1'b0;

        if (wr_en) begin
            case (address)
                2'd0: begin
                    run_d  = writedata[0];
                    cont_d = writedata[1];
                end
                2'd1: div_d   = writedata[DIV_W-1:0];
                2'd2: burst_d = writedata[CNT_W-1:0];
                default: if (writedata[1]) done_d = 1'b0;
            endcase
        end

        // FSM decisions come after register decode so hardware set/clear wins over software.
        case (state_q)
            IDLE: begin
                if (run_q) begin
                    if (!cont_q && burst_q == '0) begin
                        run_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        state_d  = HIGH;
                        phase_d  = div_eff;
                        count_d  = CNT_W'(1);
                        done_d   = 1'b0;
                        sclk_d   = 1'b1;
                        strobe_d = 1'b1;
                    end
                end
            end
            HIGH: begin
                if (phase_last) begin
                    state_d = LOW;
                    phase_d = div_eff;
                    sclk_d  = 1'b0;
                end else begin
                    phase_d = phase_q - DIV_W'(1);
                end
            end
            LOW: begin
                if (!phase_last) begin
                    phase_d = phase_q - DIV_W'(1);
                end else if (!run_q) begin
                    state_d = IDLE;
                end else if (!cont_q && count_q >= burst_q) begin
                    state_d = IDLE;
                    run_d   = 1'b0;
                    done_d  = 1'b1;
                end else begin
                    state_d  = HIGH;
                    phase_d  = div_eff;
                    sclk_d   = 1'b1;
                    strobe_d = 1'b1;
                    count_d  = (count_q == '1) ? count_q : count_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= DIV_W'(1);
            div_q    <= DIV_W'(1);
            burst_q  <= '0;
            count_q  <= '0;
            run_q    <= 1'b0;
            cont_q   <= 1'b0;
            done_q   <= 1'b0;
            sclk_q   <= 1'b0;
            strobe_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            div_q    <= div_d;
            burst_q  <= burst_d;
            count_q  <= count_d;
            run_q    <= run_d;
            cont_q   <= cont_d;
            done_q   <= done_d;
            sclk_q   <= sclk_d;
            strobe_q <= strobe_d;
        end
    end

    assign sample_clk    = sclk_q;
    assign sample_strobe = strobe_q;

`ifdef SAMPLE_CLK_IRQ_EN
    logic irq_mask_q, irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            if (wr_en && address == 2'd0) irq_mask_q <= writedata[2];
            irq_q <= done_q & irq_mask_q;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: begin
                readdata[0] = run_q;
                readdata[1] = cont_q;
`ifdef SAMPLE_CLK_IRQ_EN
                readdata[2] = irq_mask_q;
`endif
            end
            2'd1: readdata[DIV_W-1:0] = div_q;
            2'd2: readdata[CNT_W-1:0] = burst_q;
            default: begin
                readdata[0]          = busy;
                readdata[1]          = done_q;
                readdata[CNT_W+15:16] = count_q;
            end
        endcase
    end

endmodule

// File: tb/tb_sample_clk_sequencer.sv
// Self-checking bench for sample_clk_sequencer: register table, hand-written corner sequences,
// and randomized bursts checked against a waveform model built from the register settings.
module tb_sample_clk_sequencer;

    logic        clk = 1'b0;
    logic        reset, chipselect, write_n;
    logic [1:0]  address;
    logic [31:0] writedata, readdata;
    logic        sample_clk, sample_strobe;
`ifdef SAMPLE_CLK_IRQ_EN
    logic        irq;
    localparam logic [31:0] CTRL6_RB = 32'h6;
`else
    localparam logic [31:0] CTRL6_RB = 32'h2;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    sample_clk_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .address       (address),
        .chipselect    (chipselect),
        .write_n       (write_n),
        .writedata     (writedata),
        .readdata      (readdata),
        .sample_clk    (sample_clk),
`ifdef SAMPLE_CLK_IRQ_EN
        .irq           (irq),
`endif
        .sample_strobe (sample_strobe)
    );

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Write occupies the current cycle; returns at the start of the next one.
    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a;
        #1;
        d = readdata;
    endtask

    // Reference: one idle cycle, then burst pulses of d high / d low, then idle; count==burst, done set.
    task automatic run_burst(input int div, input int burst);
        int          d;
        bit          exp_clk[$];
        bit          exp_stb[$];
        logic [31:0] r;
        d = (div == 0) ? 1 : div;
        exp_clk.push_back(1'b0);
        exp_stb.push_back(1'b0);
        for (int k = 0; k < burst; k++) begin
            for (int j = 0; j < d; j++) begin
                exp_clk.push_back(1'b1);
                exp_stb.push_back(j == 0);
            end
            for (int j = 0; j < d; j++) begin
                exp_clk.push_back(1'b0);
                exp_stb.push_back(1'b0);
            end
        end
        repeat (2) begin
            exp_clk.push_back(1'b0);
            exp_stb.push_back(1'b0);
        end
        wr(2'd1, 32'(div));
        wr(2'd2, 32'(burst));
        wr(2'd0, 32'h1);
        for (int i = 0; i < exp_clk.size(); i++) begin
            check($sformatf("burst d%0d b%0d clk[%0d]", div, burst, i), 32'(sample_clk), 32'(exp_clk[i]));
            check($sformatf("burst d%0d b%0d stb[%0d]", div, burst, i), 32'(sample_strobe), 32'(exp_stb[i]));
            tick();
        end
        rd(2'd3, r);
        if (burst > 0) check("burst status", r, (32'(burst) << 16) | 32'h2);
        else           check("burst0 status", r & 32'h3, 32'h2);
        rd(2'd0, r);
        check("burst run cleared", r & 32'h1, 32'h0);
        wr(2'd3, 32'h2);
        rd(2'd3, r);
        check("done w1c", r & 32'h3, 32'h0);
    endtask

    initial begin
        vec_t        vecs[8];
        logic [31:0] r;
        bit          fr_clk[14];
        bit          fr_stb[14];

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0;
        repeat (3) tick();
        reset = 1'b0;
        check("rst sample_clk", 32'(sample_clk), 32'h0);
        check("rst strobe", 32'(sample_strobe), 32'h0);
        rd(2'd0, r); check("rst ctrl", r, 32'h0);
        rd(2'd1, r); check("rst div", r, 32'h1);
        rd(2'd2, r); check("rst burst", r, 32'h0);
        rd(2'd3, r); check("rst status", r, 32'h0);
`ifdef SAMPLE_CLK_IRQ_EN
        check("rst irq", 32'(irq), 32'h0);
`endif
        tick();

        // Register write/readback table (run bit never set here).
        vecs[0] = '{2'd0, 32'h0000_0006, CTRL6_RB};
        vecs[1] = '{2'd0, 32'hFFFF_FFFA, 32'h2};
        vecs[2] = '{2'd1, 32'hFFFF_1234, 32'h1234};
        vecs[3] = '{2'd1, 32'h0000_0000, 32'h0};
        vecs[4] = '{2'd2, 32'hABCD_0007, 32'h7};
        vecs[5] = '{2'd2, 32'h0001_0000, 32'h0};
        vecs[6] = '{2'd3, 32'hFFFF_FFFF, 32'h0};
        vecs[7] = '{2'd0, 32'h0000_0000, 32'h0};
        for (int i = 0; i < 8; i++) begin
            wr(vecs[i].addr, vecs[i].wdata);
            rd(vecs[i].addr, r);
            check($sformatf("table[%0d]", i), r, vecs[i].exp);
        end

        run_burst(3, 4);

        // DIV=0 free-run toggles every cycle; stop during a HIGH cycle.
        wr(2'd1, 32'h0);
        wr(2'd0, 32'h3);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("div0 clk[%0d]", i), 32'(sample_clk), 32'(i % 2));
            if (i == 5) wr(2'd0, 32'h0);
            else        tick();
        end
        check("div0 stop low", 32'(sample_clk), 32'h0);
        tick();
        check("div0 idle clk", 32'(sample_clk), 32'h0);
        rd(2'd3, r); check("div0 idle status", r, 32'h0003_0000);
        tick();

        // Free-run DIV=5, change to 2 mid-HIGH: current phase stays 5 cycles.
        fr_clk = '{0,1,1,1,1,1,0,0,1,1,0,0,1,1};
        fr_stb = '{0,1,0,0,0,0,0,0,1,0,0,0,1,0};
        wr(2'd1, 32'h5);
        wr(2'd0, 32'h3);
        for (int i = 0; i < 14; i++) begin
            check($sformatf("divchg clk[%0d]", i), 32'(sample_clk), 32'(fr_clk[i]));
            check($sformatf("divchg stb[%0d]", i), 32'(sample_strobe), 32'(fr_stb[i]));
            if (i == 2) wr(2'd1, 32'h2);
            else        tick();
        end
        wr(2'd0, 32'h0);
        repeat (8) tick();
        rd(2'd3, r); check("divchg stopped", r & 32'h3, 32'h0);
        check("divchg clk low", 32'(sample_clk), 32'h0);
        tick();

        // BURST=0: no pulse, done one cycle after run is registered.
        wr(2'd2, 32'h0);
        wr(2'd0, 32'h1);
        check("b0 clk n+1", 32'(sample_clk), 32'h0);
        tick();
        rd(2'd3, r); check("b0 done", r & 32'h3, 32'h2);
        rd(2'd0, r); check("b0 run cleared", r & 32'h1, 32'h0);
        check("b0 clk n+2", 32'(sample_clk), 32'h0);
        wr(2'd3, 32'h2);
        rd(2'd3, r); check("b0 w1c", r & 32'h3, 32'h0);
        tick();

        for (int it = 0; it < 10; it++) begin
            run_burst(int'($urandom_range(0, 4)), int'($urandom_range(0, 5)));
        end

        // Reset in the middle of a HIGH phase.
        wr(2'd1, 32'h4);
        wr(2'd0, 32'h3);
        repeat (4) tick();
        check("midrst pre high", 32'(sample_clk), 32'h1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midrst clk", 32'(sample_clk), 32'h0);
        rd(2'd0, r); check("midrst ctrl", r, 32'h0);
        rd(2'd1, r); check("midrst div", r, 32'h1);
        rd(2'd3, r); check("midrst status", r, 32'h0);
        tick();
        check("midrst stays low", 32'(sample_clk), 32'h0);

`ifdef SAMPLE_CLK_IRQ_EN
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h1);
        wr(2'd0, 32'h5);
        repeat (3) tick();
        rd(2'd3, r); check("irq done set", r & 32'h3, 32'h2);
        check("irq lags done", 32'(irq), 32'h0);
        tick();
        check("irq high", 32'(irq), 32'h1);
        wr(2'd3, 32'h2);
        rd(2'd3, r); check("irq done cleared", r & 32'h2, 32'h0);
        tick();
        check("irq low", 32'(irq), 32'h0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
